sr_piso_4bit_ser: RTL and testbench

Parallel-in serial-out serializer that sits directly upstream of the 4-bit SIPO shift register and drives its serial input. It accepts parallel words through a valid/ready handshake and buffers one word while another shifts out. It emits one bit per clock with a frame-start marker, so consecutive words stream with no idle gap.

---
 rtl/sr_pkg.sv | 18 +
 rtl/sr_hold_reg.sv | 37 +++
 rtl/sr_piso_4bit_ser.sv | 143 ++++++++++++++
 tb/tb_sr_piso_4bit_ser.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared types and constants for the sr_piso_4bit_ser serializer.
// Optional parity frame bit is enabled by defining SR_PISO_PARITY_EN.
package sr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } sr_state_t;

    localparam int SR_WIDTH_DFLT = 4;

    // Holds 0..WIDTH with headroom so the terminal value never wraps.
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/sr_hold_reg.sv
// One-entry holding buffer in front of the shifter. A write and a take can
// never coincide: writes need the buffer empty, takes need it full.
module sr_hold_reg
    import sr_pkg::*;
#(
    parameter int WIDTH = SR_WIDTH_DFLT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    input  logic             i_take,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_ready
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_take) begin
            r_full <= 1'b0;
        end else if (i_valid && !r_full) begin
            r_data <= i_data;
            r_full <= 1'b1;
        end
    end

    assign o_data  = r_data;
    assign o_full  = r_full;
    assign o_ready = !r_full;

endmodule

// File: rtl/sr_piso_4bit_ser.sv
// Parallel-in serial-out serializer with a one-word holding buffer and a
// frame-start marker. Define SR_PISO_PARITY_EN to append an even-parity bit.
module sr_piso_4bit_ser
    import sr_pkg::*;
#(
    parameter int WIDTH     = SR_WIDTH_DFLT,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH);

    sr_state_t        r_state, w_state_nx;
    logic [WIDTH-1:0] r_shift, w_shift_nx, w_shift_adv, w_hold_data;
    logic [CW-1:0]    r_cnt, w_cnt_nx;
    logic             r_sout, w_sout_nx;
    logic             r_sout_valid, w_sout_valid_nx;
    logic             r_frame_start, w_frame_start_nx;
    logic             w_hold_full, w_take, w_load, w_end;
    logic             w_first_bit, w_next_bit;
`ifdef SR_PISO_PARITY_EN
    logic             r_par, w_par_nx;
`endif

    sr_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk     (clk),
        .rst     (rst),
        .i_data  (pin),
        .i_valid (load_valid),
        .i_take  (w_take),
        .o_data  (w_hold_data),
        .o_full  (w_hold_full),
        .o_ready (load_ready)
    );

    // The bit after the one on sout always sits next to the outgoing end.
    assign w_first_bit = MSB_FIRST ? w_hold_data[WIDTH-1] : w_hold_data[0];
    assign w_next_bit  = MSB_FIRST ? r_shift[WIDTH-2]     : r_shift[1];
    assign w_shift_adv = MSB_FIRST ? (r_shift << 1)       : (r_shift >> 1);

    always_comb begin
        w_state_nx       = r_state;
        w_shift_nx       = r_shift;
        w_cnt_nx         = r_cnt;
        w_sout_nx        = r_sout;
        w_sout_valid_nx  = r_sout_valid;
        w_frame_start_nx = 1'b0;
        w_take           = 1'b0;
        w_load           = 1'b0;
        w_end            = 1'b0;
`ifdef SR_PISO_PARITY_EN
        w_par_nx         = r_par;
`endif
        case (r_state)
            IDLE: begin
                w_load = w_hold_full;
            end
            SHIFT: begin
                if (r_cnt != CNT_LAST) begin
                    w_sout_nx  = w_next_bit;
                    w_shift_nx = w_shift_adv;
                    w_cnt_nx   = r_cnt + CW'(1);
                end else begin
`ifdef SR_PISO_PARITY_EN
                    w_state_nx = PARITY;
                    w_sout_nx  = r_par;
`else
                    w_load = w_hold_full;
                    w_end  = !w_hold_full;
`endif
                end
            end
            PARITY: begin
`ifdef SR_PISO_PARITY_EN
                w_load = w_hold_full;
                w_end  = !w_hold_full;
`else
                w_state_nx = IDLE;
`endif
            end
            default: w_state_nx = IDLE;
        endcase

        if (w_load) begin
            w_take           = 1'b1;
            w_shift_nx       = w_hold_data;
            w_sout_nx        = w_first_bit;
            w_sout_valid_nx  = 1'b1;
            w_frame_start_nx = 1'b1;
            w_cnt_nx         = CW'(1);
            w_state_nx       = SHIFT;
`ifdef SR_PISO_PARITY_EN
            w_par_nx         = ^w_hold_data;
`endif
        end
        if (w_end) begin
            w_state_nx      = IDLE;
            w_sout_nx       = 1'b0;
            w_sout_valid_nx = 1'b0;
            w_cnt_nx        = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_shift       <= '0;
            r_cnt         <= '0;
            r_sout        <= 1'b0;
            r_sout_valid  <= 1'b0;
            r_frame_start <= 1'b0;
`ifdef SR_PISO_PARITY_EN
            r_par         <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_nx;
            r_shift       <= w_shift_nx;
            r_cnt         <= w_cnt_nx;
            r_sout        <= w_sout_nx;
            r_sout_valid  <= w_sout_valid_nx;
            r_frame_start <= w_frame_start_nx;
`ifdef SR_PISO_PARITY_EN
            r_par         <= w_par_nx;
`endif
        end
    end

    assign sout        = r_sout;
    assign sout_valid  = r_sout_valid;
    assign frame_start = r_frame_start;
    assign busy        = (r_state != IDLE) || w_hold_full;

endmodule

// File: tb/tb_sr_piso_4bit_ser.sv
// Bench for sr_piso_4bit_ser: directed cycle tables, async reset abort,
// LSB-first loopback into a SIPO model, and randomized frame-schedule model.
module tb_sr_piso_4bit_ser;

    localparam int W = 4;
`ifdef SR_PISO_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif
    localparam int NCYC = 360;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] pin = '0;
    logic         load_valid = 1'b0;
    logic         load_ready, sout, sout_valid, frame_start, busy;
    logic [W-1:0] pin2 = '0;
    logic         lv2 = 1'b0;
    logic         rdy2, sout2, sv2, fs2, busy2;

    int nchk  = 0;
    int npass = 0;

    always #5 clk = ~clk;

    sr_piso_4bit_ser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .pin(pin), .load_valid(load_valid),
        .load_ready(load_ready), .sout(sout), .sout_valid(sout_valid),
        .frame_start(frame_start), .busy(busy)
    );

    sr_piso_4bit_ser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .pin(pin2), .load_valid(lv2),
        .load_ready(rdy2), .sout(sout2), .sout_valid(sv2),
        .frame_start(fs2), .busy(busy2)
    );

    typedef struct {
        logic         lv;
        logic [W-1:0] pin;
        logic [4:0]   ex;   // {sout, sout_valid, frame_start, load_ready, busy}
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic lv, input logic [W-1:0] p, input logic [4:0] ex);
        vec_t t;
        t.lv  = lv;
        t.pin = p;
        t.ex  = ex;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    endtask

    // Reference schedule, indexed by clock edge count after reset release.
    logic m_v [0:511];
    logic m_s [0:511];
    logic m_f [0:511];
    logic m_h [0:511];
    logic m_b [0:511];

    function automatic logic frame_bit(input logic [W-1:0] w, input int j);
        if (j >= W) return ^w;
        return w[W-1-j];
    endfunction

    initial begin
        int           nxt_free;
        int           e, s;
        logic         acc;
        logic [W-1:0] w;
        logic [W-1:0] sipo;
        int           got;

        // Directed table: single word, back-to-back pair, backpressure.
`ifdef SR_PISO_PARITY_EN
        tbl.push_back(mk(1'b1, 4'b0111, 5'b00010));
        tbl.push_back(mk(1'b0, 4'h0,    5'b00001));
        tbl.push_back(mk(1'b0, 4'h0,    5'b01111));
        tbl.push_back(mk(1'b0, 4'h0,    5'b11011));
        tbl.push_back(mk(1'b0, 4'h0,    5'b11011));
        tbl.push_back(mk(1'b0, 4'h0,    5'b11011));
        tbl.push_back(mk(1'b0, 4'h0,    5'b11011));
        tbl.push_back(mk(1'b0, 4'h0,    5'b00010));
`else
        tbl.push_back(mk(1'b1, 4'hA, 5'b00010));
        tbl.push_back(mk(1'b0, 4'h0, 5'b00001));
        tbl.push_back(mk(1'b0, 4'h0, 5'b11111));
        tbl.push_back(mk(1'b0, 4'h0, 5'b01011));
        tbl.push_back(mk(1'b0, 4'h0, 5'b11011));
        tbl.push_back(mk(1'b0, 4'h0, 5'b01011));
        tbl.push_back(mk(1'b1, 4'hA, 5'b00010));
        tbl.push_back(mk(1'b1, 4'h5, 5'b00001));
        tbl.push_back(mk(1'b1, 4'h5, 5'b11111));
        tbl.push_back(mk(1'b1, 4'hF, 5'b01001));
        tbl.push_back(mk(1'b1, 4'hF, 5'b11001));
        tbl.push_back(mk(1'b1, 4'hF, 5'b01001));
        tbl.push_back(mk(1'b1, 4'hF, 5'b01111));
        tbl.push_back(mk(1'b0, 4'h0, 5'b11001));
        tbl.push_back(mk(1'b0, 4'h0, 5'b01001));
        tbl.push_back(mk(1'b0, 4'h0, 5'b11001));
        tbl.push_back(mk(1'b0, 4'h0, 5'b11111));
        tbl.push_back(mk(1'b0, 4'h0, 5'b11011));
        tbl.push_back(mk(1'b0, 4'h0, 5'b11011));
        tbl.push_back(mk(1'b0, 4'h0, 5'b11011));
        tbl.push_back(mk(1'b0, 4'h0, 5'b00010));
`endif

        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            chk($sformatf("tbl_row%0d", i), {sout, sout_valid, frame_start, load_ready, busy}, tbl[i].ex);
            load_valid = tbl[i].lv;
            pin        = tbl[i].pin;
            @(negedge clk);
        end
        load_valid = 1'b0;

        // Async reset two bits into 4'hC with 4'h3 held.
        load_valid = 1'b1; pin = 4'hC;
        @(negedge clk);
        pin = 4'h3;
        @(negedge clk);
        @(negedge clk);
        load_valid = 1'b0;
        chk("abort_pre_sout", sout, 1'b1);
        chk("abort_pre_ready", load_ready, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("abort_outs", {sout, sout_valid, frame_start, load_ready, busy}, 5'b00010);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("abort_quiet", {sout_valid, busy}, 2'b00);
        end

        // LSB-first words looped into a SIPO that shifts in at the MSB end.
        for (int n = 0; n < 3; n++) begin
            w = (n == 0) ? 4'b0001 : W'($urandom);
            lv2 = 1'b1; pin2 = w;
            @(negedge clk);
            lv2 = 1'b0;
            sipo = '0;
            got  = 0;
            for (int k = 0; k < 12 && got < W; k++) begin
                @(negedge clk);
                if (sv2) begin
                    chk("lsb_bit", sout2, w[got]);
                    chk("lsb_fs", fs2, (got == 0));
                    sipo = {sout2, sipo[W-1:1]};
                    got++;
                end
            end
            chk("lsb_count", got, W);
            chk("lsb_pout", sipo, w);
            repeat (3) @(negedge clk);
        end

        // Random traffic against a frame-schedule model.
        rst = 1'b0;
        for (int i = 0; i < 512; i++) begin
            m_v[i] = 1'b0; m_s[i] = 1'b0; m_f[i] = 1'b0; m_h[i] = 1'b0; m_b[i] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        nxt_free = 0;
        for (int c = 0; c < NCYC; c++) begin
            chk("rnd_valid", sout_valid, m_v[c]);
            if (m_v[c]) chk("rnd_sout", sout, m_s[c]);
            chk("rnd_fs", frame_start, m_f[c]);
            chk("rnd_ready", load_ready, !m_h[c]);
            chk("rnd_busy", busy, m_b[c]);
            load_valid = (c < 300) && ($urandom_range(0, 3) != 0);
            pin        = W'($urandom);
            acc        = load_valid && !m_h[c];
            w          = pin;
            @(posedge clk);
            if (acc) begin
                e = c + 1;
                s = (e + 1 > nxt_free) ? e + 1 : nxt_free;
                for (int k = e; k < s; k++) m_h[k] = 1'b1;
                for (int k = e; k < s + FL; k++) m_b[k] = 1'b1;
                for (int j = 0; j < FL; j++) begin
                    m_v[s+j] = 1'b1;
                    m_f[s+j] = (j == 0);
                    m_s[s+j] = frame_bit(w, j);
                end
                nxt_free = s + FL;
            end
            @(negedge clk);
        end
        load_valid = 1'b0;

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
